// File: rtl/word_ping_pkg.sv
// Shared widths, blink state encoding and stage-1 payload for the PING banner renderer.
package word_ping_pkg;

  localparam int unsigned WORD_W = 128;
  localparam int unsigned WORD_H = 32;
  localparam int unsigned ROW_AW = 5;
  localparam int unsigned COL_AW = 7;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned PIX_W  = 10;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } blink_state_e;

  typedef struct packed {
    logic              in_box;
    logic              vid;
    logic [COL_AW-1:0] col;
  } stage1_t;

endpackage

// File: rtl/word_ping_blink.sv
// Frame-counted blink FSM; visible is high only while the banner is in its ON phase.
module word_ping_blink
  import word_ping_pkg::*;
#(
  parameter int unsigned BLINK_ON_FRAMES  = 30,
  parameter int unsigned BLINK_OFF_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic frame_tick,
  output logic visible
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(BLINK_ON_FRAMES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(BLINK_OFF_FRAMES - 1);
  localparam bit               STEADY   = (BLINK_OFF_FRAMES == 0);

  blink_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             visible_q, visible_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      visible_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      visible_q <= visible_d;
    end
  end

  // Dropping enable wins over a coincident frame_tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
        ST_ON: begin
          if (STEADY) begin
            cnt_d = '0;
          end else if (frame_tick) begin
            if (cnt_q == ON_LAST) begin
              state_d = ST_BLANK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_BLANK: begin
          if (frame_tick) begin
            if (cnt_q == OFF_LAST) begin
              state_d = ST_ON;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    visible_d = (state_d == ST_ON);
  end

  assign visible = visible_q;

endmodule

// File: rtl/word_ping_render.sv
// Two-stage banner renderer: box mapping + ROM row address, then pixel select and colour.
// Define WORD_PING_SCALE2_EN to draw the banner at 2x scale.
module word_ping_render
  import word_ping_pkg::*;
#(
  parameter int unsigned      X0               = 256,
  parameter int unsigned      Y0               = 224,
  parameter logic [RGB_W-1:0] FG_COLOR         = 12'hFFF,
  parameter logic [RGB_W-1:0] BG_COLOR         = 12'h000,
  parameter int unsigned      BLINK_ON_FRAMES  = 30,
  parameter int unsigned      BLINK_OFF_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  pixel_x,
  input  logic [PIX_W-1:0]  pixel_y,
  input  logic              video_on,
  input  logic              frame_tick,
  input  logic              enable,
  output logic [ROW_AW-1:0] drom_addr_num,
  input  logic [WORD_W-1:0] drom_data_num,
  output logic              word_on,
  output logic [RGB_W-1:0]  rgb
);

  localparam int unsigned CMP_W = PIX_W + 1;
`ifdef WORD_PING_SCALE2_EN
  localparam int unsigned BOX_W = 2 * WORD_W;
  localparam int unsigned BOX_H = 2 * WORD_H;
`else
  localparam int unsigned BOX_W = WORD_W;
  localparam int unsigned BOX_H = WORD_H;
`endif
  localparam logic [CMP_W-1:0] X_LO = CMP_W'(X0);
  localparam logic [CMP_W-1:0] X_HI = CMP_W'(X0 + BOX_W);
  localparam logic [CMP_W-1:0] Y_LO = CMP_W'(Y0);
  localparam logic [CMP_W-1:0] Y_HI = CMP_W'(Y0 + BOX_H);

  logic [CMP_W-1:0]  px, py;
  logic [ROW_AW-1:0] row;
  stage1_t           s1_q, s1_d;
  logic [ROW_AW-1:0] addr_q, addr_d;
  logic              word_on_q, word_on_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              visible;

  word_ping_blink #(
    .BLINK_ON_FRAMES (BLINK_ON_FRAMES),
    .BLINK_OFF_FRAMES(BLINK_OFF_FRAMES)
  ) u_blink (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .frame_tick(frame_tick),
    .visible   (visible)
  );

  // Stage 1: box test in 11 bits so the edges never wrap; row address holds outside the box.
  always_comb begin
    px          = {1'b0, pixel_x};
    py          = {1'b0, pixel_y};
    s1_d.in_box = (px >= X_LO) && (px < X_HI) && (py >= Y_LO) && (py < Y_HI);
    s1_d.vid    = video_on;
`ifdef WORD_PING_SCALE2_EN
    s1_d.col    = COL_AW'((px - X_LO) >> 1);
    row         = ROW_AW'((py - Y_LO) >> 1);
`else
    s1_d.col    = COL_AW'(px - X_LO);
    row         = ROW_AW'(py - Y_LO);
`endif
    addr_d      = s1_d.in_box ? row : addr_q;
  end

  // Stage 2: ROM data is already valid for the registered row address.
  always_comb begin
    word_on_d = s1_q.in_box && s1_q.vid && visible && drom_data_num[s1_q.col];
    if (word_on_d) begin
      rgb_d = FG_COLOR;
    end else if (s1_q.vid) begin
      rgb_d = BG_COLOR;
    end else begin
      rgb_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      addr_q    <= '0;
      word_on_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      addr_q    <= addr_d;
      word_on_q <= word_on_d;
      rgb_q     <= rgb_d;
    end
  end

  assign drom_addr_num = addr_q;
  assign word_on       = word_on_q;
  assign rgb           = rgb_q;

endmodule

// File: tb/tb_word_ping_render.sv
// Directed bench for word_ping_render: box mapping, ROM addressing, latency and blink sequencing.
module tb_word_ping_render;

  localparam int unsigned X0 = 256;
  localparam int unsigned Y0 = 224;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h123;

  logic         clk;
  logic         reset;
  logic [9:0]   pixel_x;
  logic [9:0]   pixel_y;
  logic         video_on;
  logic         frame_tick;
  logic         enable;
  logic [4:0]   drom_addr_num;
  logic [127:0] drom_data_num;
  logic         word_on;
  logic [11:0]  rgb;

  int n_checks = 0;
  int n_pass   = 0;
  int want_vis[6] = '{1, 1, 0, 1, 1, 0};

  word_ping_render #(
    .X0              (X0),
    .Y0              (Y0),
    .FG_COLOR        (FG),
    .BG_COLOR        (BG),
    .BLINK_ON_FRAMES (2),
    .BLINK_OFF_FRAMES(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .video_on     (video_on),
    .frame_tick   (frame_tick),
    .enable       (enable),
    .drom_addr_num(drom_addr_num),
    .drom_data_num(drom_data_num),
    .word_on      (word_on),
    .rgb          (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: odd columns lit, with row 7 inverted so row addressing is observable.
  function automatic logic [127:0] rom_row(input logic [4:0] r);
    logic [127:0] v;
    for (int c = 0; c < 128; c++) v[c] = ((c % 2) == 1) != (r == 5'd7);
    return v;
  endfunction

  always_comb drom_data_num = rom_row(drom_addr_num);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic expect_out(input string tag, input logic on, input logic [11:0] col,
                            input logic [4:0] addr);
    check({tag, ".word_on"}, 32'(word_on), 32'(on));
    check({tag, ".rgb"}, 32'(rgb), 32'(col));
    check({tag, ".addr"}, 32'(drom_addr_num), 32'(addr));
  endtask

  // Hold one pixel for the two pipeline stages, then sample just after the edge.
  task automatic apply(input int x, input int y, input logic v);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = v;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic tick_frame();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; frame_tick = 1'b0;
    video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 12'h000, 5'd0);

    reset  = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    #1;
    tick_frame();

`ifdef WORD_PING_SCALE2_EN
    apply(X0 + 2, Y0, 1'b1);        expect_out("s2_col1a", 1'b1, FG, 5'd0);
    apply(X0 + 3, Y0, 1'b1);        expect_out("s2_col1b", 1'b1, FG, 5'd0);
    apply(X0 + 1, Y0, 1'b1);        expect_out("s2_col0", 1'b0, BG, 5'd0);
    apply(X0, Y0 + 63, 1'b1);       expect_out("s2_row31", 1'b0, BG, 5'd31);
    apply(X0 + 255, Y0 + 62, 1'b1); expect_out("s2_corner", 1'b1, FG, 5'd31);
    apply(X0 + 256, Y0, 1'b1);      expect_out("s2_right", 1'b0, BG, 5'd31);
    apply(X0, Y0 + 64, 1'b1);       expect_out("s2_below", 1'b0, BG, 5'd31);
    apply(X0, Y0 + 14, 1'b1);       expect_out("s2_row7a", 1'b1, FG, 5'd7);
    apply(X0, Y0 + 15, 1'b1);       expect_out("s2_row7b", 1'b1, FG, 5'd7);
    apply(X0 + 2, Y0, 1'b0);        expect_out("s2_novid", 1'b0, 12'h000, 5'd0);
`else
    apply(X0, Y0, 1'b1);            expect_out("origin", 1'b0, BG, 5'd0);
    pixel_x = 10'(X0 + 1);
    @(posedge clk);
    #1;
    check("latency_1clk.word_on", 32'(word_on), 32'd0);
    @(posedge clk);
    #1;
    expect_out("latency_2clk", 1'b1, FG, 5'd0);
    apply(X0 + 127, Y0 + 31, 1'b1); expect_out("corner", 1'b1, FG, 5'd31);
    apply(X0 + 128, Y0, 1'b1);      expect_out("right", 1'b0, BG, 5'd31);
    apply(X0 - 1, Y0, 1'b1);        expect_out("left", 1'b0, BG, 5'd31);
    apply(X0, Y0 + 32, 1'b1);       expect_out("below", 1'b0, BG, 5'd31);
    apply(X0, Y0 + 7, 1'b1);        expect_out("row7_c0", 1'b1, FG, 5'd7);
    apply(X0 + 1, Y0 + 7, 1'b1);    expect_out("row7_c1", 1'b0, BG, 5'd7);
    apply(X0 + 1, Y0, 1'b0);        expect_out("novid", 1'b0, 12'h000, 5'd0);
`endif

    // Blink: restart from a fresh ON phase, then watch a lit pixel across frames.
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable   = 1'b1;
    pixel_x  = 10'(X0 + 3);
    pixel_y  = 10'(Y0);
    video_on = 1'b1;
    for (int f = 0; f < 6; f++) begin
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("blink_frame%0d", f), 32'(word_on), 32'(want_vis[f]));
      tick_frame();
    end

    tick_frame();
    repeat (3) @(posedge clk);
    #1;
    check("pre_drop.word_on", 32'(word_on), 32'd1);

    // One-cycle enable drop coinciding with frame_tick.
    enable     = 1'b0;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    enable     = 1'b1;
    frame_tick = 1'b0;
    @(posedge clk);
    #1;
    check("drop.word_on", 32'(word_on), 32'd0);
    check("drop.rgb", 32'(rgb), 32'(BG));
    repeat (2) @(posedge clk);
    #1;
    check("reenable.word_on", 32'(word_on), 32'd1);

    tick_frame();
    repeat (3) @(posedge clk);
    #1;
    check("fresh_tick1.word_on", 32'(word_on), 32'd1);
    tick_frame();
    repeat (3) @(posedge clk);
    #1;
    check("fresh_tick2.word_on", 32'(word_on), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
